uart_tx_queue: RTL

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// Queued 8N1 UART transmitter: a small byte FIFO feeding a serializer.
// The serializer runs at OVERSAMPLE clocks per bit, and its frames follow each other with no gap.
module uart_tx_queue #(
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] io_dataIn_bits,
  input  logic       io_dataIn_valid,
  output logic       io_dataIn_accept,
  output logic       io_dataIn_ready,
  output logic       io_pair_tx,
  output logic       io_busy,
  output logic [2:0] io_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    CNT_FULL  = 3'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  typedef struct packed {
    state_t        state;
    logic [TW-1:0] tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tx;
    logic          ready;
  } ser_t;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic          push, pop, tick_end;
  ser_t          cur, nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign io_dataIn_accept = (count != CNT_FULL);
  assign push             = io_dataIn_valid && io_dataIn_accept;
  assign io_pair_tx       = cur.tx;
  assign io_dataIn_ready  = cur.ready;
  assign io_busy          = (cur.state != IDLE) || (count != 3'd0);
  assign io_count         = count;

  always_ff @(posedge clock) begin
    if (reset)
      cur <= '{state: IDLE, tick: '0, bit_idx: '0, shift: '0, tx: 1'b1, ready: 1'b0};
    else
      cur <= nxt;
  end

  always_comb begin
    nxt       = cur;
    nxt.ready = 1'b0;
    pop       = 1'b0;
    tick_end  = (cur.tick == TICK_LAST);
    if (cur.state != IDLE)
      nxt.tick = tick_end ? '0 : cur.tick + 1'b1;
    case (cur.state)
      IDLE: begin
        if (count != 3'd0) begin
          pop       = 1'b1;
          nxt.state = START;
          nxt.tick  = '0;
          nxt.shift = mem[rd_ptr];
          nxt.tx    = 1'b0;
        end
      end
      START: begin
        if (tick_end) begin
          nxt.state   = DATA;
          nxt.bit_idx = '0;
          nxt.tx      = cur.shift[0];
        end
      end
      DATA: begin
        if (tick_end) begin
          if (cur.bit_idx == 3'd7) begin
            nxt.state = STOP;
            nxt.tx    = 1'b1;
          end else begin
            nxt.shift   = cur.shift >> 1;
            nxt.bit_idx = cur.bit_idx + 3'd1;
            nxt.tx      = cur.shift[1];
          end
        end
      end
      STOP: begin
        if (tick_end) begin
          nxt.ready = 1'b1;
          // Chain straight into the next start bit when more data is queued
          if (count != 3'd0) begin
            pop       = 1'b1;
            nxt.state = START;
            nxt.shift = mem[rd_ptr];
            nxt.tx    = 1'b0;
          end else begin
            nxt.state = IDLE;
          end
        end
      end
      default: nxt.state = IDLE;
    endcase
  end

  // FIFO; reset wins over a coincident push, so that byte is dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= io_dataIn_bits;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end
endmodule
